// File: rtl/xmem_pkg.sv
// Shared types and default geometry for the xmem streaming memory block.
package xmem_pkg;

    localparam int unsigned XMEM_DEF_BW    = 4;
    localparam int unsigned XMEM_DEF_ROW   = 8;
    localparam int unsigned XMEM_DEF_DEPTH = 2048;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } xmem_state_e;

    function automatic int unsigned xmem_word_w(input int unsigned bw, input int unsigned row);
        return bw * row;
    endfunction

endpackage

// File: rtl/xmem_stream_ctrl_if.sv
// Host write port, burst request port and streamed output of the xmem block.
interface xmem_stream_ctrl_if
    import xmem_pkg::*;
#(
    parameter int unsigned bw    = XMEM_DEF_BW,
    parameter int unsigned row   = XMEM_DEF_ROW,
    parameter int unsigned depth = XMEM_DEF_DEPTH
);

    localparam int unsigned aw = $clog2(depth);
    localparam int unsigned lw = aw + 1;
    localparam int unsigned W  = xmem_word_w(bw, row);

    logic          wr_en;
    logic [aw-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          wr_drop;
    logic          rd_start;
    logic [aw-1:0] rd_base;
    logic [lw-1:0] rd_len;
    logic          rd_busy;
    logic          rd_done;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_start, rd_base, rd_len, out_ready,
        input  wr_drop, rd_busy, rd_done, out_valid, out_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_start, rd_base, rd_len, out_ready,
        output wr_drop, rd_busy, rd_done, out_valid, out_data
    );

endinterface

// File: rtl/xmem_skid2.sv
// Two-entry valid/ready FIFO; head entry drives the output, occupancy is exported
// so the producer can throttle itself and never overflow it.
module xmem_skid2 #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         pop;

    assign valid_o = (count_q != 2'd0);
    assign data_o  = head_q;
    assign count_o = count_q;
    assign pop     = valid_o & ready_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push_i) begin
                    head_d  = push_data_i;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                case ({push_i, pop})
                    2'b11: head_d = push_data_i;
                    2'b10: begin
                        tail_d  = push_data_i;
                        count_d = 2'd2;
                    end
                    2'b01: count_d = 2'd0;
                    default: ;
                endcase
            end
            default: begin
                // Full: only a pop makes room, so a push is accepted only alongside it.
                if (pop) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = push_data_i;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/xmem_stream_ctrl.sv
// Activation/weight memory with single-word host writes and a throttled burst
// read engine streaming consecutive (wrapping) words through a 2-entry skid buffer.
module xmem_stream_ctrl
    import xmem_pkg::*;
#(
    parameter int unsigned bw    = XMEM_DEF_BW,
    parameter int unsigned row   = XMEM_DEF_ROW,
    parameter int unsigned depth = XMEM_DEF_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    xmem_stream_ctrl_if.slave  bus
);

    localparam int unsigned aw = $clog2(depth);
    localparam int unsigned lw = aw + 1;
    localparam int unsigned W  = xmem_word_w(bw, row);

    xmem_state_e   state_q, state_d;
    logic [aw-1:0] addr_q, addr_d;
    logic [lw-1:0] iss_left_q, iss_left_d;
    logic [lw-1:0] hs_left_q, hs_left_d;
    logic          done_q, done_d;
    logic          drop_q, drop_d;
    logic          mem_we;
    logic          issue;
    logic          handshake;
    logic [1:0]    occ;
    logic [W-1:0]  rd_word;
    logic [W-1:0]  mem [depth];

    // The skid entry written on issue acts as the memory's read register,
    // giving the 1-cycle read latency without a separate in-flight stage.
    assign rd_word   = mem[addr_q];
    assign handshake = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        iss_left_d = iss_left_q;
        hs_left_d  = hs_left_q;
        done_d     = 1'b0;
        drop_d     = 1'b0;
        mem_we     = 1'b0;
        issue      = 1'b0;

        if (handshake) begin
            hs_left_d = hs_left_q - lw'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.rd_start) begin
                    drop_d = bus.wr_en;
                    if (bus.rd_len != '0) begin
                        addr_d     = bus.rd_base;
                        iss_left_d = bus.rd_len;
                        hs_left_d  = bus.rd_len;
                        state_d    = ST_READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    mem_we = bus.wr_en;
                end
            end
            ST_READ: begin
                drop_d = bus.wr_en;
                if (occ < 2'd2) begin
                    issue      = 1'b1;
                    addr_d     = addr_q + aw'(1);
                    iss_left_d = iss_left_q - lw'(1);
                    if (iss_left_q == lw'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                drop_d = bus.wr_en;
                if (handshake && (hs_left_q == lw'(1))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            iss_left_q <= '0;
            hs_left_q  <= '0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            iss_left_q <= iss_left_d;
            hs_left_q  <= hs_left_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.rd_busy = (state_q != ST_IDLE);
    assign bus.rd_done = done_q;
    assign bus.wr_drop = drop_q;

    xmem_skid2 #(.W(W)) u_skid (
        .clk_i       (clk),
        .rst_i       (reset),
        .push_i      (issue),
        .push_data_i (rd_word),
        .ready_i     (bus.out_ready),
        .valid_o     (bus.out_valid),
        .data_o      (bus.out_data),
        .count_o     (occ)
    );

endmodule

// File: tb/tb_xmem_stream_ctrl.sv
// Randomised bench for xmem_stream_ctrl against an array-based memory model.
module tb_xmem_stream_ctrl;
    import xmem_pkg::*;

    localparam int unsigned BW    = 4;
    localparam int unsigned ROW   = 8;
    localparam int unsigned DEPTH = 2048;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned W     = BW * ROW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    xmem_stream_ctrl_if #(.bw(BW), .row(ROW), .depth(DEPTH)) bus ();

    xmem_stream_ctrl #(.bw(BW), .row(ROW), .depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [W-1:0] ref_mem [DEPTH];
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int addr, input logic [W-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_data = data;
        tick();
        bus.wr_en = 1'b0;
        ref_mem[addr] = data;
    endtask

    function automatic logic pick_ready(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 2) return !(c >= 2 && c <= 6);
        return ($urandom_range(0, 2) != 0);
    endfunction

    // mode: 0 ready always high (timing checked), 1 random ready, 2 ready low in cycles 2-6
    task automatic run_burst(input int base, input int len, input int mode,
                             input bit illegal, input bit conflict);
        logic [W-1:0] expq[$];
        logic [W-1:0] prev_data;
        bit           prev_stall;
        bit           exp_drop;
        int           got;
        int           c;
        int           last_hs;
        for (int i = 0; i < len; i++) expq.push_back(ref_mem[(base + i) % DEPTH]);

        bus.rd_start  = 1'b1;
        bus.rd_base   = AW'(base);
        bus.rd_len    = LW'(len);
        bus.out_ready = pick_ready(mode, 0);
        if (conflict) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(base);
            bus.wr_data = ~ref_mem[base];
        end
        @(negedge clk);
        check_eq("busy_c0", bus.rd_busy, 1'b0);
        tick();
        bus.rd_start = 1'b0;
        bus.wr_en    = 1'b0;

        c = 1; got = 0; prev_stall = 1'b0; last_hs = -1; prev_data = '0;
        while (got < len && c < len * 40 + 100) begin
            bus.out_ready = pick_ready(mode, c);
            if (illegal && c == 2) begin
                bus.wr_en    = 1'b1;
                bus.wr_addr  = AW'((base + len - 1) % DEPTH);
                bus.wr_data  = ~ref_mem[(base + len - 1) % DEPTH];
                bus.rd_start = 1'b1;
                bus.rd_base  = AW'((base + 7) % DEPTH);
                bus.rd_len   = LW'(3);
            end
            @(negedge clk);
            check_eq("busy", bus.rd_busy, 1'b1);
            check_eq("done_early", bus.rd_done, 1'b0);
            exp_drop = (conflict && c == 1) || (illegal && c == 3);
            check_eq("wr_drop", bus.wr_drop, exp_drop);
            if (c == 1) check_eq("valid_c1", bus.out_valid, 1'b0);
            if (prev_stall) begin
                check_eq("hold_valid", bus.out_valid, 1'b1);
                check_eq("hold_data", bus.out_data, prev_data);
            end
            if (mode == 2 && c >= 2 && c <= 6) check_eq("stall_head", bus.out_data, expq[0]);
            if (bus.out_valid && bus.out_ready) begin
                check_eq("data", bus.out_data, expq.pop_front());
                got++;
                last_hs = c;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            tick();
            bus.wr_en    = 1'b0;
            bus.rd_start = 1'b0;
            c++;
        end
        check_eq("burst_words", got, len);
        if (mode == 0) check_eq("last_hs_cycle", last_hs, len + 1);

        @(negedge clk);
        check_eq("done_pulse", bus.rd_done, 1'b1);
        check_eq("busy_end", bus.rd_busy, 1'b0);
        check_eq("valid_end", bus.out_valid, 1'b0);
        tick();
        @(negedge clk);
        check_eq("done_once", bus.rd_done, 1'b0);
        tick();
    endtask

    initial begin
        reset         = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_start  = 1'b0;
        bus.rd_base   = '0;
        bus.rd_len    = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", bus.rd_busy, 1'b0);
        check_eq("rst_done", bus.rd_done, 1'b0);
        check_eq("rst_valid", bus.out_valid, 1'b0);
        check_eq("rst_drop", bus.wr_drop, 1'b0);
        check_eq("rst_data", bus.out_data, '0);
        tick();

        for (int a = 0; a < int'(DEPTH); a++) write_word(a, W'($urandom));
        write_word(4, 32'h11111111);
        write_word(5, 32'h22222222);
        write_word(6, 32'h33333333);
        write_word(7, 32'h44444444);

        run_burst(4, 4, 0, 1'b0, 1'b0);
        run_burst(4, 4, 2, 1'b0, 1'b0);
        run_burst(2046, 4, 0, 1'b0, 1'b0);

        bus.rd_start  = 1'b1;
        bus.rd_base   = AW'(5);
        bus.rd_len    = '0;
        bus.out_ready = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        @(negedge clk);
        check_eq("zlen_done", bus.rd_done, 1'b1);
        check_eq("zlen_busy", bus.rd_busy, 1'b0);
        check_eq("zlen_valid", bus.out_valid, 1'b0);
        tick();
        @(negedge clk);
        check_eq("zlen_done_once", bus.rd_done, 1'b0);
        check_eq("zlen_valid2", bus.out_valid, 1'b0);
        tick();

        run_burst(0, DEPTH, 0, 1'b0, 1'b0);

        run_burst(20, 6, 0, 1'b1, 1'b0);
        run_burst(20, 6, 1, 1'b0, 1'b0);
        run_burst(30, 5, 1, 1'b0, 1'b1);

        bus.rd_start  = 1'b1;
        bus.rd_base   = AW'(100);
        bus.rd_len    = LW'(8);
        bus.out_ready = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_busy", bus.rd_busy, 1'b0);
        check_eq("mid_rst_done", bus.rd_done, 1'b0);
        check_eq("mid_rst_valid", bus.out_valid, 1'b0);
        check_eq("mid_rst_drop", bus.wr_drop, 1'b0);
        check_eq("mid_rst_data", bus.out_data, '0);
        tick();
        @(negedge clk);
        check_eq("post_rst_done", bus.rd_done, 1'b0);
        check_eq("post_rst_valid", bus.out_valid, 1'b0);
        tick();
        run_burst(100, 8, 0, 1'b0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            int wa;
            int b;
            wa = int'($urandom_range(0, DEPTH - 1));
            write_word(wa, W'($urandom));
            b = int'($urandom_range(0, DEPTH - 1));
            run_burst(b, int'($urandom_range(1, 40)), (k % 3 == 0) ? 0 : 1, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
